// File: rtl/wave_ch_ctrl.sv
// Wave-channel register slice and control: NR30-NR34 byte registers, trigger
// sequencing, length counter, frequency timer and wave-position counter.
module wave_ch_ctrl #(
    parameter int FREQ_W = 11,
    parameter int LEN_W  = 8,
    parameter int POS_W  = 5,
    parameter int VOL_W  = 2
) (
    input  logic             cery_2mhz,
    input  logic             napu_reset,
    input  logic             apu_wr,
    input  logic             cpu_rd,
    input  logic [2:0]       addr,
    input  logic [7:0]       d_in,
    output logic [7:0]       d_out,
    output logic             d_oe,
    input  logic             tick_en,
    input  logic             len_tick,
    input  logic             test_rd,
    output logic             dac_en,
    output logic [VOL_W-1:0] volume,
    output logic             ch_active,
    output logic [POS_W-1:0] wave_pos,
    output logic             pos_step,
    output logic             trig
);

    localparam logic [LEN_W:0]    LEN_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [FREQ_W-1:0] TMR_MAX  = '1;

    logic              dac_en_q, dac_en_d;
    logic [VOL_W-1:0]  volume_q, volume_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              len_en_q, len_en_d;
    logic [LEN_W:0]    len_cnt_q, len_cnt_d;
    logic [FREQ_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0]  wave_pos_q, wave_pos_d;
    logic              ch_active_q, ch_active_d;
    logic              trig_q, trig_d;
    logic              pos_step_q, pos_step_d;
    logic              trig_pending_q, trig_pending_d;

    logic wr_nr30, wr_nr31, wr_nr32, wr_nr33, wr_nr34;

    assign wr_nr30 = apu_wr && (addr == 3'd0);
    assign wr_nr31 = apu_wr && (addr == 3'd1);
    assign wr_nr32 = apu_wr && (addr == 3'd2);
    assign wr_nr33 = apu_wr && (addr == 3'd3);
    assign wr_nr34 = apu_wr && (addr == 3'd4);

    always_comb begin
        dac_en_d       = dac_en_q;
        volume_d       = volume_q;
        freq_d         = freq_q;
        len_en_d       = len_en_q;
        len_cnt_d      = len_cnt_q;
        timer_d        = timer_q;
        wave_pos_d     = wave_pos_q;
        ch_active_d    = ch_active_q;
        trig_d         = 1'b0;
        pos_step_d     = 1'b0;
        trig_pending_d = trig_pending_q;

        // A taken trigger suppresses both the timer tick and the length tick.
        if (trig_pending_q) begin
            trig_d         = 1'b1;
            trig_pending_d = 1'b0;
            timer_d        = freq_q;
            wave_pos_d     = '0;
            ch_active_d    = dac_en_q;
            if (len_cnt_q == '0) begin
                len_cnt_d = LEN_FULL;
            end
        end else begin
            if (ch_active_q && tick_en) begin
                if (timer_q == TMR_MAX) begin
                    timer_d    = freq_q;
                    wave_pos_d = wave_pos_q + POS_W'(1);
                    pos_step_d = 1'b1;
                end else begin
                    timer_d = timer_q + FREQ_W'(1);
                end
            end
            if (len_tick && len_en_q && (len_cnt_q != '0) && !wr_nr31) begin
                len_cnt_d = len_cnt_q - (LEN_W+1)'(1);
                if (len_cnt_q == (LEN_W+1)'(1)) begin
                    ch_active_d = 1'b0;
                end
            end
        end

        if (wr_nr30) dac_en_d = d_in[7];
        if (wr_nr31) len_cnt_d = LEN_FULL - {1'b0, d_in[LEN_W-1:0]};
        if (wr_nr32) volume_d = d_in[4+VOL_W:5];
        if (wr_nr33) freq_d[7:0] = d_in;
        if (wr_nr34) begin
            freq_d[FREQ_W-1:8] = d_in[FREQ_W-9:0];
            len_en_d           = d_in[6];
            if (d_in[7]) trig_pending_d = 1'b1;
        end

        if (!dac_en_q) ch_active_d = 1'b0;
    end

    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            dac_en_q       <= 1'b0;
            volume_q       <= '0;
            freq_q         <= '0;
            len_en_q       <= 1'b0;
            len_cnt_q      <= '0;
            timer_q        <= '0;
            wave_pos_q     <= '0;
            ch_active_q    <= 1'b0;
            trig_q         <= 1'b0;
            pos_step_q     <= 1'b0;
            trig_pending_q <= 1'b0;
        end else begin
            dac_en_q       <= dac_en_d;
            volume_q       <= volume_d;
            freq_q         <= freq_d;
            len_en_q       <= len_en_d;
            len_cnt_q      <= len_cnt_d;
            timer_q        <= timer_d;
            wave_pos_q     <= wave_pos_d;
            ch_active_q    <= ch_active_d;
            trig_q         <= trig_d;
            pos_step_q     <= pos_step_d;
            trig_pending_q <= trig_pending_d;
        end
    end

    // Unused read bits float high, matching the legacy bus.
    always_comb begin
        d_out = 8'hFF;
        case (addr)
            3'd0: d_out = {dac_en_q, 7'h7F};
            3'd2: d_out[4+VOL_W:5] = volume_q;
            3'd3: if (test_rd) d_out = timer_q[7:0];
            3'd4: d_out[6] = len_en_q;
            default: ;
        endcase
    end

    assign d_oe      = cpu_rd && (addr <= 3'd4);
    assign dac_en    = dac_en_q;
    assign volume    = volume_q;
    assign ch_active = ch_active_q;
    assign wave_pos  = wave_pos_q;
    assign pos_step  = pos_step_q;
    assign trig      = trig_q;

endmodule

// File: tb/tb_wave_ch_ctrl.sv
// Directed bench for wave_ch_ctrl: register readback, trigger timing,
// length counter, DAC gating, priorities and asynchronous reset.
module tb_wave_ch_ctrl;

    logic       cery_2mhz;
    logic       napu_reset;
    logic       apu_wr;
    logic       cpu_rd;
    logic [2:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       tick_en;
    logic       len_tick;
    logic       test_rd;
    logic       dac_en;
    logic [1:0] volume;
    logic       ch_active;
    logic [4:0] wave_pos;
    logic       pos_step;
    logic       trig;

    int n_checks = 0;
    int n_fail   = 0;

    wave_ch_ctrl dut (
        .cery_2mhz (cery_2mhz),
        .napu_reset(napu_reset),
        .apu_wr    (apu_wr),
        .cpu_rd    (cpu_rd),
        .addr      (addr),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .tick_en   (tick_en),
        .len_tick  (len_tick),
        .test_rd   (test_rd),
        .dac_en    (dac_en),
        .volume    (volume),
        .ch_active (ch_active),
        .wave_pos  (wave_pos),
        .pos_step  (pos_step),
        .trig      (trig)
    );

    initial begin
        cery_2mhz = 1'b0;
        forever #5 cery_2mhz = ~cery_2mhz;
    end

    task automatic step();
        @(posedge cery_2mhz);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] v);
        addr   = a;
        d_in   = v;
        apu_wr = 1'b1;
        step();
        apu_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [5];
        exp_rd = '{8'h7F, 8'hFF, 8'h9F, 8'hFF, 8'hBF};
        #12;
        if ({dac_en, volume, ch_active, wave_pos, pos_step, trig} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0", {dac_en, volume, ch_active, wave_pos, pos_step, trig});
        end
        n_checks++;
        napu_reset = 1'b1;
        step();
        cpu_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = 3'(i);
            #1;
            if ({d_oe, d_out} !== {1'b1, exp_rd[i]}) begin
                n_fail++;
                $display("FAIL reset_read%0d: got oe=%0b d=%h want oe=1 d=%h", i, d_oe, d_out, exp_rd[i]);
            end
            n_checks++;
        end
        addr = 3'd6;
        #1;
        if ({d_oe, d_out} !== {1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL unmapped_read: got oe=%0b d=%h want oe=0 d=ff", d_oe, d_out);
        end
        n_checks++;
    endtask

    task automatic test_volume();
        wr(3'd2, 8'h40);
        addr = 3'd2;
        #1;
        if ({volume, d_out} !== {2'd2, 8'hDF}) begin
            n_fail++;
            $display("FAIL vol_2: got vol=%0d d=%h want vol=2 d=df", volume, d_out);
        end
        n_checks++;
        wr(3'd2, 8'h60);
        addr = 3'd2;
        #1;
        if ({volume, d_out} !== {2'd3, 8'hFF}) begin
            n_fail++;
            $display("FAIL vol_3: got vol=%0d d=%h want vol=3 d=ff", volume, d_out);
        end
        n_checks++;
    endtask

    task automatic test_trigger();
        wr(3'd0, 8'h80);
        wr(3'd3, 8'hFE);
        wr(3'd4, 8'h87);
        if (trig !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_early: got %0b want 0", trig);
        end
        n_checks++;
        step();
        if ({trig, ch_active, wave_pos} !== {1'b1, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL trig_take: got trig=%0b act=%0b pos=%0d want 1 1 0", trig, ch_active, wave_pos);
        end
        n_checks++;
        step();
        if (trig !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_pulse: got %0b want 0", trig);
        end
        n_checks++;
        test_rd = 1'b1;
        addr    = 3'd3;
        #1;
        if (d_out !== 8'hFE) begin
            n_fail++;
            $display("FAIL timer_rd: got %h want fe", d_out);
        end
        n_checks++;
        test_rd = 1'b0;
        tick_en = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if ({pos_step, wave_pos} !== {(i % 2 == 0), 5'((i / 2) % 32)}) begin
                n_fail++;
                $display("FAIL wave_step%0d: got step=%0b pos=%0d want step=%0b pos=%0d",
                         i, pos_step, wave_pos, (i % 2 == 0), (i / 2) % 32);
            end
            n_checks++;
        end
        tick_en = 1'b0;
    endtask

    task automatic test_length_expiry();
        wr(3'd1, 8'hFC);
        wr(3'd4, 8'hC0);
        step();
        addr = 3'd4;
        #1;
        if ({trig, ch_active, d_out} !== {1'b1, 1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL len_trig: got trig=%0b act=%0b nr34=%h want 1 1 ff", trig, ch_active, d_out);
        end
        n_checks++;
        len_tick = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (ch_active !== (i < 4)) begin
                n_fail++;
                $display("FAIL len_tick%0d: got act=%0b want %0b", i, ch_active, (i < 4));
            end
            n_checks++;
        end
        len_tick = 1'b0;
    endtask

    task automatic test_length_reload();
        wr(3'd4, 8'h80);
        step();
        if ({trig, ch_active} !== 2'b11) begin
            n_fail++;
            $display("FAIL reload_trig: got trig=%0b act=%0b want 1 1", trig, ch_active);
        end
        n_checks++;
        len_tick = 1'b1;
        repeat (256) step();
        len_tick = 1'b0;
        if (ch_active !== 1'b1) begin
            n_fail++;
            $display("FAIL len_disabled: got act=%0b want 1", ch_active);
        end
        n_checks++;
        wr(3'd4, 8'h40);
        step();
        if (trig !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trig_d7_0: got %0b want 0", trig);
        end
        n_checks++;
        len_tick = 1'b1;
        repeat (255) step();
        if (ch_active !== 1'b1) begin
            n_fail++;
            $display("FAIL len255: got act=%0b want 1", ch_active);
        end
        n_checks++;
        step();
        len_tick = 1'b0;
        if (ch_active !== 1'b0) begin
            n_fail++;
            $display("FAIL len256: got act=%0b want 0", ch_active);
        end
        n_checks++;
    endtask

    task automatic test_dac_priority();
        wr(3'd3, 8'hFE);
        wr(3'd4, 8'h87);
        step();
        tick_en = 1'b1;
        repeat (6) step();
        tick_en = 1'b0;
        if ({ch_active, wave_pos} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL pre_dac: got act=%0b pos=%0d want 1 3", ch_active, wave_pos);
        end
        n_checks++;
        wr(3'd0, 8'h00);
        step();
        if ({dac_en, ch_active, wave_pos} !== {1'b0, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL dac_off: got dac=%0b act=%0b pos=%0d want 0 0 3", dac_en, ch_active, wave_pos);
        end
        n_checks++;
        wr(3'd4, 8'h87);
        step();
        if ({trig, ch_active, wave_pos} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL trig_dac_off: got trig=%0b act=%0b pos=%0d want 1 0 0", trig, ch_active, wave_pos);
        end
        n_checks++;
        wr(3'd0, 8'h80);
        wr(3'd1, 8'hFE);
        wr(3'd4, 8'hC7);
        len_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ch_active !== (i < 2)) begin
                n_fail++;
                $display("FAIL trig_vs_len%0d: got act=%0b want %0b", i, ch_active, (i < 2));
            end
            n_checks++;
        end
        len_tick = 1'b0;
    endtask

    task automatic test_async_reset();
        wr(3'd4, 8'h87);
        step();
        tick_en = 1'b1;
        repeat (3) step();
        wr(3'd4, 8'h80);
        if (ch_active !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got act=%0b want 1", ch_active);
        end
        n_checks++;
        #3;
        napu_reset = 1'b0;
        #1;
        if ({dac_en, volume, ch_active, wave_pos, pos_step, trig} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_rst: got %b want 0", {dac_en, volume, ch_active, wave_pos, pos_step, trig});
        end
        n_checks++;
        #2;
        napu_reset = 1'b1;
        tick_en    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({trig, ch_active} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_rst%0d: got trig=%0b act=%0b want 0 0", i, trig, ch_active);
            end
            n_checks++;
        end
        addr = 3'd4;
        #1;
        if (d_out !== 8'hBF) begin
            n_fail++;
            $display("FAIL post_rst_nr34: got %h want bf", d_out);
        end
        n_checks++;
    endtask

    initial begin
        napu_reset = 1'b0;
        apu_wr     = 1'b0;
        cpu_rd     = 1'b0;
        addr       = 3'd0;
        d_in       = 8'h00;
        tick_en    = 1'b0;
        len_tick   = 1'b0;
        test_rd    = 1'b0;
        test_reset();
        test_volume();
        test_trigger();
        test_length_expiry();
        test_length_reload();
        test_dac_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
